// File: rtl/pipelined_adder.sv
// Pipelined two's-complement add/subtract with valid/ready flow control.
// The carry chain is cut into SEG-bit segments, one register stage per segment.
module pipelined_adder #(
    parameter int WIDTH = 8,
    parameter int SEG   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int STAGES = WIDTH / SEG;
    // Operands shrink by SEG bits per stage and the resolved sum grows by SEG bits,
    // so both travel in flat vectors packed stage after stage.
    localparam int OPW = STAGES * WIDTH - SEG * STAGES * (STAGES - 1) / 2;
    localparam int SW  = SEG * STAGES * (STAGES + 1) / 2;

    if (WIDTH < 2 || SEG < 1 || (WIDTH % SEG) != 0) begin : g_param_check
        $error("pipelined_adder: WIDTH must be >= 2 and an integer multiple of SEG");
    end

    logic              w_adv;
    logic [STAGES:0]   w_vld_pipe;
    logic [STAGES:0]   w_c;
    logic [OPW-1:0]    w_a;
    logic [OPW-1:0]    w_b;
    logic [SW-1:0]     w_s;
    logic              r_ovf;

    assign w_adv              = ~w_vld_pipe[STAGES] | out_ready;
    assign in_ready           = w_adv;
    assign w_vld_pipe[0]      = in_valid;
    assign w_a[WIDTH-1:0]     = a;
    assign w_b[WIDTH-1:0]     = sub ? ~b : b;
    assign w_c[0]             = cin ^ sub;

    assign out_valid = w_vld_pipe[STAGES];
    assign sum       = w_s[SW-WIDTH +: WIDTH];
    assign cout      = w_c[STAGES];
    assign ovf       = r_ovf;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int R = WIDTH - k * SEG;
        localparam int O = k * WIDTH - SEG * k * (k - 1) / 2;
        localparam int P = SEG * k * (k + 1) / 2;

        logic [SEG:0]           w_seg;
        logic [(k+1)*SEG-1:0]   w_s_nxt;
        logic                   r_vld;
        logic                   r_c;
        logic [(k+1)*SEG-1:0]   r_s;

        assign w_seg = {1'b0, w_a[O +: SEG]} + {1'b0, w_b[O +: SEG]} + {{SEG{1'b0}}, w_c[k]};

        if (k == 0) begin : g_s_first
            assign w_s_nxt = w_seg[SEG-1:0];
        end else begin : g_s_rest
            assign w_s_nxt = {w_seg[SEG-1:0], w_s[SEG*(k-1)*k/2 +: k*SEG]};
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_vld <= 1'b0;
                r_c   <= 1'b0;
                r_s   <= '0;
            end else if (w_adv) begin
                r_vld <= w_vld_pipe[k];
                r_c   <= w_seg[SEG];
                r_s   <= w_s_nxt;
            end
        end

        assign w_vld_pipe[k+1]      = r_vld;
        assign w_c[k+1]             = r_c;
        assign w_s[P +: (k+1)*SEG]  = r_s;

        if (k < STAGES - 1) begin : g_skew
            logic [R-SEG-1:0] r_a;
            logic [R-SEG-1:0] r_b;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_a <= '0;
                    r_b <= '0;
                end else if (w_adv) begin
                    r_a <= w_a[O+SEG +: R-SEG];
                    r_b <= w_b[O+SEG +: R-SEG];
                end
            end

            assign w_a[O+R +: R-SEG] = r_a;
            assign w_b[O+R +: R-SEG] = r_b;
        end else begin : g_last
            // Carry into the MSB is recovered as a^b^s at that bit.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_ovf <= 1'b0;
                end else if (w_adv) begin
                    r_ovf <= w_seg[SEG] ^ w_a[O+SEG-1] ^ w_b[O+SEG-1] ^ w_seg[SEG-1];
                end
            end
        end
    end
endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench for pipelined_adder: 8/4, 16/4 and 8/8 configurations.
module tb_pipelined_adder;
    typedef struct {
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    exp_t pq[$];
    exp_t qq[$];

    // 8-bit, SEG=4
    logic       p_in_valid = 0, p_in_ready, p_cin = 0, p_sub = 0;
    logic       p_out_valid, p_out_ready = 0, p_cout, p_ovf;
    logic [7:0] p_a = 0, p_b = 0, p_sum;
    // 16-bit, SEG=4
    logic        q_in_valid = 0, q_in_ready, q_cin = 0, q_sub = 0;
    logic        q_out_valid, q_out_ready = 0, q_cout, q_ovf;
    logic [15:0] q_a = 0, q_b = 0, q_sum;
    // 8-bit, SEG=8
    logic       d_in_valid = 0, d_in_ready, d_cin = 0, d_sub = 0;
    logic       d_out_valid, d_out_ready = 0, d_cout, d_ovf;
    logic [7:0] d_a = 0, d_b = 0, d_sum;

    pipelined_adder #(.WIDTH(8), .SEG(4)) u_p (
        .clk(clk), .rst(rst), .in_valid(p_in_valid), .in_ready(p_in_ready),
        .a(p_a), .b(p_b), .cin(p_cin), .sub(p_sub), .out_valid(p_out_valid),
        .out_ready(p_out_ready), .sum(p_sum), .cout(p_cout), .ovf(p_ovf));

    pipelined_adder #(.WIDTH(16), .SEG(4)) u_q (
        .clk(clk), .rst(rst), .in_valid(q_in_valid), .in_ready(q_in_ready),
        .a(q_a), .b(q_b), .cin(q_cin), .sub(q_sub), .out_valid(q_out_valid),
        .out_ready(q_out_ready), .sum(q_sum), .cout(q_cout), .ovf(q_ovf));

    pipelined_adder #(.WIDTH(8), .SEG(8)) u_d (
        .clk(clk), .rst(rst), .in_valid(d_in_valid), .in_ready(d_in_ready),
        .a(d_a), .b(d_b), .cin(d_cin), .sub(d_sub), .out_valid(d_out_valid),
        .out_ready(d_out_ready), .sum(d_sum), .cout(d_cout), .ovf(d_ovf));

    // Reference: signed overflow when operand signs agree and the result sign differs.
    function automatic exp_t model(int w, logic [15:0] a, logic [15:0] b, logic cin, logic sub);
        exp_t        e;
        logic [15:0] mask, be;
        logic [16:0] full;
        mask   = (w == 16) ? 16'hFFFF : 16'h00FF;
        be     = (sub ? ~b : b) & mask;
        full   = {1'b0, a & mask} + {1'b0, be} + {16'd0, (sub ? ~cin : cin)};
        e.sum  = full[15:0] & mask;
        e.cout = (w == 16) ? full[16] : full[8];
        e.ovf  = (a[w-1] == be[w-1]) && (e.sum[w-1] != a[w-1]);
        e.cyc  = 0;
        return e;
    endfunction

    task automatic test_reset();
        #2;
        n_checks++; if (p_out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_out_valid: got %b want 0", p_out_valid); end
        n_checks++; if (p_sum !== 8'h00) begin n_errors++; $display("FAIL reset_sum: got %h want 00", p_sum); end
        n_checks++; if ({p_cout, p_ovf} !== 2'b00) begin n_errors++; $display("FAIL reset_flags: got %b want 00", {p_cout, p_ovf}); end
        n_checks++; if (p_in_ready !== 1'b1) begin n_errors++; $display("FAIL reset_in_ready: got %b want 1", p_in_ready); end
        n_checks++; if ({q_out_valid, d_out_valid} !== 2'b00) begin n_errors++; $display("FAIL reset_other_valid: got %b want 00", {q_out_valid, d_out_valid}); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_directed();
        logic [7:0] va [3] = '{8'hFF, 8'h7F, 8'h10};
        logic [7:0] vb [3] = '{8'h01, 8'h01, 8'h20};
        logic       vs [3] = '{1'b0, 1'b0, 1'b1};
        logic [7:0] es [3] = '{8'h00, 8'h80, 8'hF0};
        logic       ec [3] = '{1'b1, 1'b0, 1'b0};
        logic       eo [3] = '{1'b0, 1'b1, 1'b0};
        int   i = 0;
        exp_t e;
        pq.delete();
        for (int cyc = 0; cyc < 12; cyc++) begin
            @(negedge clk);
            p_out_ready = 1'b1;
            p_in_valid  = (i < 3);
            if (i < 3) begin p_a = va[i]; p_b = vb[i]; p_cin = 1'b0; p_sub = vs[i]; end
            #1;
            if (p_out_valid) begin
                n_checks++;
                if (pq.size() == 0) begin
                    n_errors++; $display("FAIL directed_extra: got sum %h with nothing pending", p_sum);
                end else begin
                    e = pq.pop_front();
                    if ({p_sum, p_cout, p_ovf} !== {e.sum[7:0], e.cout, e.ovf}) begin
                        n_errors++; $display("FAIL directed_result: got %h/%b/%b want %h/%b/%b", p_sum, p_cout, p_ovf, e.sum[7:0], e.cout, e.ovf);
                    end
                    n_checks++;
                    if (cyc - e.cyc != 2) begin n_errors++; $display("FAIL directed_latency: got %0d want 2", cyc - e.cyc); end
                end
            end
            if (p_in_valid && p_in_ready) begin
                e.sum = {8'h00, es[i]}; e.cout = ec[i]; e.ovf = eo[i]; e.cyc = cyc;
                pq.push_back(e);
                i++;
            end
        end
        p_in_valid = 1'b0;
        n_checks++; if (pq.size() != 0 || i != 3) begin n_errors++; $display("FAIL directed_drain: got %0d pending %0d sent want 0 pending 3 sent", pq.size(), i); end
    endtask

    task automatic test_stream();
        int   sent = 0;
        int   got  = 0;
        exp_t e;
        qq.delete();
        q_out_ready = 1'b1;
        for (int cyc = 0; cyc < 120 && (sent < 100 || qq.size() > 0); cyc++) begin
            @(negedge clk);
            if (sent < 100) begin
                q_in_valid = 1'b1;
                q_a = 16'($urandom); q_b = 16'($urandom);
                q_cin = 1'($urandom); q_sub = 1'($urandom);
            end else begin
                q_in_valid = 1'b0;
            end
            #1;
            n_checks++; if (q_in_ready !== 1'b1) begin n_errors++; $display("FAIL stream_in_ready: got %b want 1 at cycle %0d", q_in_ready, cyc); end
            if (q_out_valid) begin
                n_checks++;
                if (qq.size() == 0) begin
                    n_errors++; $display("FAIL stream_extra: got sum %h with nothing pending", q_sum);
                end else begin
                    e = qq.pop_front();
                    got++;
                    if ({q_sum, q_cout, q_ovf} !== {e.sum, e.cout, e.ovf}) begin
                        n_errors++; $display("FAIL stream_result: got %h/%b/%b want %h/%b/%b", q_sum, q_cout, q_ovf, e.sum, e.cout, e.ovf);
                    end
                    n_checks++;
                    if (cyc - e.cyc != 4) begin n_errors++; $display("FAIL stream_latency: got %0d want 4", cyc - e.cyc); end
                end
            end
            if (q_in_valid && q_in_ready) begin
                e = model(16, q_a, q_b, q_cin, q_sub);
                e.cyc = cyc;
                qq.push_back(e);
                sent++;
            end
        end
        q_in_valid = 1'b0;
        n_checks++; if (got != 100 || qq.size() != 0) begin n_errors++; $display("FAIL stream_count: got %0d results %0d pending want 100 and 0", got, qq.size()); end
    endtask

    task automatic test_backpressure();
        int         sent = 0;
        int         got  = 0;
        logic       need_new = 1'b1;
        logic [9:0] held = '0;
        exp_t       e;
        pq.delete();
        for (int cyc = 0; cyc < 30 && (sent < 6 || pq.size() > 0); cyc++) begin
            @(negedge clk);
            p_out_ready = (cyc >= 7);
            if (need_new) begin
                if (sent < 6) begin
                    p_in_valid = 1'b1;
                    p_a = 8'($urandom); p_b = 8'($urandom);
                    p_cin = 1'($urandom); p_sub = 1'($urandom);
                end else begin
                    p_in_valid = 1'b0;
                end
            end
            need_new = 1'b0;
            #1;
            if (cyc == 2) held = {p_sum, p_cout, p_ovf};
            if (cyc >= 2 && cyc <= 6) begin
                n_checks++; if (p_in_ready !== 1'b0) begin n_errors++; $display("FAIL bp_in_ready: got %b want 0 at cycle %0d", p_in_ready, cyc); end
                n_checks++; if (p_out_valid !== 1'b1) begin n_errors++; $display("FAIL bp_out_valid: got %b want 1 at cycle %0d", p_out_valid, cyc); end
                if (cyc > 2) begin
                    n_checks++;
                    if ({p_sum, p_cout, p_ovf} !== held) begin n_errors++; $display("FAIL bp_hold: got %h want %h", {p_sum, p_cout, p_ovf}, held); end
                end
            end
            if (p_out_valid && p_out_ready) begin
                n_checks++;
                if (pq.size() == 0) begin
                    n_errors++; $display("FAIL bp_extra: got sum %h with nothing pending", p_sum);
                end else begin
                    e = pq.pop_front();
                    got++;
                    if ({p_sum, p_cout, p_ovf} !== {e.sum[7:0], e.cout, e.ovf}) begin
                        n_errors++; $display("FAIL bp_result: got %h/%b/%b want %h/%b/%b", p_sum, p_cout, p_ovf, e.sum[7:0], e.cout, e.ovf);
                    end
                end
            end
            if (p_in_valid && p_in_ready) begin
                e = model(8, {8'h00, p_a}, {8'h00, p_b}, p_cin, p_sub);
                e.cyc = cyc;
                pq.push_back(e);
                sent++;
                need_new = 1'b1;
            end
        end
        p_in_valid = 1'b0;
        n_checks++; if (got != 6 || pq.size() != 0) begin n_errors++; $display("FAIL bp_count: got %0d results %0d pending want 6 and 0", got, pq.size()); end
    endtask

    task automatic test_reset_midstream();
        int got = 0;
        @(negedge clk);
        p_out_ready = 1'b1; p_in_valid = 1'b1;
        p_a = 8'h7F; p_b = 8'h01; p_cin = 1'b0; p_sub = 1'b0;
        @(negedge clk);
        p_a = 8'h22; p_b = 8'h33;
        @(negedge clk);
        p_in_valid = 1'b0;
        #1;
        n_checks++; if ({p_out_valid, p_sum} !== {1'b1, 8'h80}) begin n_errors++; $display("FAIL midrst_before: got %b/%h want 1/80", p_out_valid, p_sum); end
        #1 rst = 1'b1;
        #1;
        n_checks++; if (p_out_valid !== 1'b0) begin n_errors++; $display("FAIL midrst_out_valid: got %b want 0", p_out_valid); end
        n_checks++; if ({p_sum, p_cout, p_ovf} !== 10'd0) begin n_errors++; $display("FAIL midrst_outputs: got %h/%b/%b want 00/0/0", p_sum, p_cout, p_ovf); end
        @(negedge clk);
        rst = 1'b0;
        p_in_valid = 1'b1; p_a = 8'h03; p_b = 8'h04;
        for (int cyc = 0; cyc < 8; cyc++) begin
            @(negedge clk);
            p_in_valid = 1'b0;
            #1;
            if (p_out_valid) begin
                got++;
                n_checks++;
                if ({p_sum, p_cout, p_ovf} !== {8'h07, 1'b0, 1'b0} || cyc != 1) begin
                    n_errors++; $display("FAIL midrst_new_beat: got %h/%b/%b at cycle %0d want 07/0/0 at cycle 1", p_sum, p_cout, p_ovf, cyc);
                end
            end
        end
        n_checks++; if (got != 1) begin n_errors++; $display("FAIL midrst_count: got %0d results want 1", got); end
    endtask

    task automatic test_degenerate();
        logic [7:0] va [3] = '{8'h80, 8'h00, 8'h80};
        logic [7:0] vb [3] = '{8'h80, 8'h01, 8'h01};
        logic       vc [3] = '{1'b1, 1'b0, 1'b0};
        logic       vs [3] = '{1'b0, 1'b1, 1'b1};
        logic [7:0] es [3] = '{8'h01, 8'hFF, 8'h7F};
        logic       ec [3] = '{1'b1, 1'b0, 1'b1};
        logic       eo [3] = '{1'b1, 1'b0, 1'b1};
        exp_t dq[$];
        exp_t e;
        int   i = 0;
        for (int cyc = 0; cyc < 8; cyc++) begin
            @(negedge clk);
            d_out_ready = 1'b1;
            d_in_valid  = (i < 3);
            if (i < 3) begin d_a = va[i]; d_b = vb[i]; d_cin = vc[i]; d_sub = vs[i]; end
            #1;
            if (d_out_valid) begin
                n_checks++;
                if (dq.size() == 0) begin
                    n_errors++; $display("FAIL degen_extra: got sum %h with nothing pending", d_sum);
                end else begin
                    e = dq.pop_front();
                    if ({d_sum, d_cout, d_ovf} !== {e.sum[7:0], e.cout, e.ovf} || cyc - e.cyc != 1) begin
                        n_errors++; $display("FAIL degen_result: got %h/%b/%b lat %0d want %h/%b/%b lat 1", d_sum, d_cout, d_ovf, cyc - e.cyc, e.sum[7:0], e.cout, e.ovf);
                    end
                end
            end
            if (d_in_valid && d_in_ready) begin
                e.sum = {8'h00, es[i]}; e.cout = ec[i]; e.ovf = eo[i]; e.cyc = cyc;
                dq.push_back(e);
                i++;
            end
        end
        d_in_valid = 1'b0;
        n_checks++; if (dq.size() != 0 || i != 3) begin n_errors++; $display("FAIL degen_drain: got %0d pending %0d sent want 0 and 3", dq.size(), i); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_directed();
        test_stream();
        test_backpressure();
        test_reset_midstream();
        test_degenerate();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
